yuv_pixel_fetch: RTL and testbench
==================================

YUV_PIXEL_FETCH -- requirements
Module: yuv_pixel_fetch

Interface
REQ-001 The block SHALL have one clock domain and a synchronous, active-high reset.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: reset  in  1  synchronous active-high reset.
REQ-004 Port: req_valid / req_ready  in / out  1 / 1  pixel request handshake.
REQ-005 Port: row, col  in  10 each  pixel coordinate, passed through to the output.
REQ-006 Port: y_addr[15:0], y_pos[5:0]  in  Y word address in FB1 and bit offset within that word.
REQ-007 Port: u_buf  in  1  U location: 0 = FB1, 1 = FB2.
REQ-008 Port: u_addr[15:0], u_pos[7:0]  in  U word address and bit offset.
REQ-009 Port: v_addr[12:0], v_pos[7:0]  in  V word address in FB2 and bit offset.
REQ-010 Port: fb1_rd, fb1_addr[15:0]  out  FB1 read strobe and address.
REQ-011 Port: fb1_data[39:0]  in  FB1 read word, 5 bytes per word.
REQ-012 Port: fb2_rd, fb2_addr[15:0]  out  FB2 read strobe and address.
REQ-013 Port: fb2_data[143:0]  in  FB2 read word, 18 bytes per word.
REQ-014 Port: out_valid / out_ready  out / in  1 / 1  pixel result handshake.
REQ-015 Port: out_y, out_u, out_v  out  8 each  fetched samples.
REQ-016 Port: out_row, out_col  out  10 each  coordinate of the result.
REQ-017 Port: pos_err  out  1  sticky flag: an offset exceeded its word width.

Function
REQ-018 Memory contract: each fbN_data SHALL be valid in the cycle after the cycle in which fbN_rd=1, for the address presented with that strobe.
REQ-019 FSM states SHALL be IDLE, RD_A, RD_B, CAP and OUT; req_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE, req_valid=1 SHALL latch row, col, all addresses, offsets and u_buf, then move to RD_A; inputs are ignored in every other state.
REQ-021 RD_A SHALL assert fb1_rd with fb1_addr=y_addr, and fb2_rd with fb2_addr={3'b0,v_addr}, then move to RD_B.
REQ-022 RD_B SHALL capture Y=fb1_data[y_pos+:8] and V=fb2_data[v_pos+:8].
REQ-023 RD_B SHALL issue the U read on FB1 if u_buf=0, or on FB2 if u_buf=1, with address u_addr, then move to CAP.
REQ-024 CAP SHALL capture U from the data of the selected buffer at u_pos, then move to OUT.
REQ-025 OUT SHALL hold out_valid=1 with stable outputs until out_ready=1, then return to IDLE.
REQ-026 Latency: for an acceptance in cycle 0 and out_ready held high, out_valid SHALL be 1 in cycle 4; sustained throughput is 1 pixel per 5 cycles.
REQ-027 fb1_rd and fb2_rd SHALL be 0 in IDLE, CAP and OUT; the buffer not selected for U SHALL see rd=0 in RD_B; no strobe lasts longer than 1 cycle.
REQ-028 Range limits: FB1 offsets SHALL be at most 32 and FB2 offsets at most 136.
REQ-029 An offset beyond its limit SHALL yield byte 8'h00 for that sample and set pos_err; pos_err is cleared only by reset.
REQ-030 Offsets not a multiple of 8 SHALL be used as given, as a bit slice; no rounding is applied.
REQ-031 out_row and out_col SHALL equal the latched row and col.
REQ-032 If out_ready=1 in the same cycle that OUT is entered, the handshake completes that cycle.

Reset
REQ-033 Reset SHALL force state=IDLE, out_valid=0, fb1_rd=0, fb2_rd=0, pos_err=0.
REQ-034 Reset SHALL force addresses, out_y, out_u, out_v, out_row and out_col to 0.
REQ-035 Reset asserted mid-transaction SHALL abandon the fetch: no out_valid pulse and no further strobes from that request.
REQ-036 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-037 Scenario Y/V fetch: u_buf=0, y_addr=3, y_pos=16, v_addr=7, v_pos=136, FB1[3]=40'h11_22_33_44_55, FB2[7] top byte=0xAB -> out_y=0x33, out_v=0xAB, fb1_rd pulses twice (addresses 3 then u_addr).
REQ-038 Scenario U in FB2: u_buf=1, u_addr=0x0100, u_pos=0 -> fb2_rd pulses in RD_A (v_addr) and RD_B (0x0100), fb1_rd only once, out_u = FB2[0x100][7:0].
REQ-039 Scenario backpressure: out_ready=0 for 10 cycles -> out_valid and outputs stable, req_ready=0 throughout, then one handshake on release.
REQ-040 Scenario back-to-back: req_valid held high, out_ready=1 -> accepts every 5 cycles, row/col order preserved.
REQ-041 Scenario offset error: y_pos=40 -> out_y=0x00, pos_err=1, pos_err remains 1 until reset.
REQ-042 Scenario mid-fetch reset: reset asserted in RD_B -> no out_valid pulse, IDLE the next cycle, next request fetched correctly.

Source files
------------

// File: rtl/yuv_pixel_fetch.sv
// -----------------------------------------------------------------------------
// yuv_pixel_fetch
//
// Fetches one Y, U and V sample for a pixel from two frame buffers.
// FB1 is 40 bits wide (5 bytes per word). FB2 is 144 bits wide (18 bytes per word).
// Y always lives in FB1 and V always lives in FB2.
// U lives in either buffer, as selected per request.
//
// A request is accepted in IDLE. The FSM then does the following:
//   RD_A : read Y (FB1) and V (FB2) in parallel.
//   RD_B : capture Y and V, then read U from its buffer.
//   CAP  : capture U.
//   OUT  : present the result until the consumer accepts it.
// Each buffer returns its data in the cycle after its read strobe.
// For an acceptance in cycle 0, out_valid rises in cycle 4.
//
// Sample extraction takes the 8 bits starting at the given bit offset.
// An offset whose byte would run past the top of the word gives 8'h00.
// Such an offset also sets the sticky pos_err flag, which only reset clears.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   req_valid / req_ready   request handshake (ready only in IDLE)
//   row, col                pixel coordinate, returned on out_row/out_col
//   y_addr, y_pos           Y word address in FB1, bit offset
//   u_buf, u_addr, u_pos    U buffer select (0=FB1, 1=FB2), address, offset
//   v_addr, v_pos           V word address in FB2, bit offset
//   fb1_rd/addr/data        FB1 read port
//   fb2_rd/addr/data        FB2 read port
//   out_valid / out_ready   result handshake
//   out_y, out_u, out_v     fetched samples
//   out_row, out_col        coordinate of the result
//   pos_err                 sticky out-of-range offset flag
// -----------------------------------------------------------------------------
module yuv_pixel_fetch (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [9:0]   row,
  input  logic [9:0]   col,
  input  logic [15:0]  y_addr,
  input  logic [5:0]   y_pos,
  input  logic         u_buf,
  input  logic [15:0]  u_addr,
  input  logic [7:0]   u_pos,
  input  logic [12:0]  v_addr,
  input  logic [7:0]   v_pos,
  output logic         fb1_rd,
  output logic [15:0]  fb1_addr,
  input  logic [39:0]  fb1_data,
  output logic         fb2_rd,
  output logic [15:0]  fb2_addr,
  input  logic [143:0] fb2_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_y,
  output logic [7:0]   out_u,
  output logic [7:0]   out_v,
  output logic [9:0]   out_row,
  output logic [9:0]   out_col,
  output logic         pos_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_A = 3'd1;
  localparam logic [2:0] RD_B = 3'd2;
  localparam logic [2:0] CAP  = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;

  // Highest offset whose 8-bit slice still fits inside the word.
  localparam logic [7:0] FB1_MAX_POS = 8'd32;
  localparam logic [7:0] FB2_MAX_POS = 8'd136;

  // Byte at an arbitrary bit offset of an FB1 word; 0 when out of range.
  function automatic logic [7:0] fb1_byte(input logic [39:0] word, input logic [7:0] pos);
    logic [39:0] shifted;
    shifted = word >> pos;
    if (pos > FB1_MAX_POS) begin
      fb1_byte = 8'h00;
    end else begin
      fb1_byte = shifted[7:0];
    end
  endfunction

  // Byte at an arbitrary bit offset of an FB2 word; 0 when out of range.
  function automatic logic [7:0] fb2_byte(input logic [143:0] word, input logic [7:0] pos);
    logic [143:0] shifted;
    shifted = word >> pos;
    if (pos > FB2_MAX_POS) begin
      fb2_byte = 8'h00;
    end else begin
      fb2_byte = shifted[7:0];
    end
  endfunction

  logic [2:0]  state_q,     state_d;
  logic [5:0]  y_pos_q,     y_pos_d;
  logic        u_buf_q,     u_buf_d;
  logic [15:0] u_addr_q,    u_addr_d;
  logic [7:0]  u_pos_q,     u_pos_d;
  logic [7:0]  v_pos_q,     v_pos_d;
  logic        fb1_rd_q,    fb1_rd_d;
  logic [15:0] fb1_addr_q,  fb1_addr_d;
  logic        fb2_rd_q,    fb2_rd_d;
  logic [15:0] fb2_addr_q,  fb2_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_y_q,     out_y_d;
  logic [7:0]  out_u_q,     out_u_d;
  logic [7:0]  out_v_q,     out_v_d;
  logic [9:0]  out_row_q,   out_row_d;
  logic [9:0]  out_col_q,   out_col_d;
  logic        pos_err_q,   pos_err_d;

  // Next-state logic.
  // Read strobes are registered, so each strobe is set on the transition
  // into the state that must show it. This makes each strobe a single-cycle pulse.
  always_comb begin
    state_d     = state_q;
    y_pos_d     = y_pos_q;
    u_buf_d     = u_buf_q;
    u_addr_d    = u_addr_q;
    u_pos_d     = u_pos_q;
    v_pos_d     = v_pos_q;
    fb1_rd_d    = 1'b0;
    fb1_addr_d  = fb1_addr_q;
    fb2_rd_d    = 1'b0;
    fb2_addr_d  = fb2_addr_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_u_d     = out_u_q;
    out_v_d     = out_v_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    pos_err_d   = pos_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          y_pos_d    = y_pos;
          u_buf_d    = u_buf;
          u_addr_d   = u_addr;
          u_pos_d    = u_pos;
          v_pos_d    = v_pos;
          out_row_d  = row;
          out_col_d  = col;
          // The Y and V reads leave in RD_A, straight from the request.
          fb1_rd_d   = 1'b1;
          fb1_addr_d = y_addr;
          fb2_rd_d   = 1'b1;
          fb2_addr_d = {3'b000, v_addr};
          state_d    = RD_A;
        end else begin
          state_d    = IDLE;
        end
      end

      RD_A: begin
        // The U read is issued in RD_B on the buffer chosen by u_buf.
        if (u_buf_q) begin
          fb2_rd_d   = 1'b1;
          fb2_addr_d = u_addr_q;
        end else begin
          fb1_rd_d   = 1'b1;
          fb1_addr_d = u_addr_q;
        end
        state_d = RD_B;
      end

      RD_B: begin
        out_y_d   = fb1_byte(fb1_data, {2'b00, y_pos_q});
        out_v_d   = fb2_byte(fb2_data, v_pos_q);
        pos_err_d = pos_err_q | ({2'b00, y_pos_q} > FB1_MAX_POS) | (v_pos_q > FB2_MAX_POS);
        state_d   = CAP;
      end

      CAP: begin
        if (u_buf_q) begin
          out_u_d   = fb2_byte(fb2_data, u_pos_q);
          pos_err_d = pos_err_q | (u_pos_q > FB2_MAX_POS);
        end else begin
          out_u_d   = fb1_byte(fb1_data, u_pos_q);
          pos_err_d = pos_err_q | (u_pos_q > FB1_MAX_POS);
        end
        out_valid_d = 1'b1;
        state_d     = OUT;
      end

      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any fetch in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      y_pos_q     <= 6'd0;
      u_buf_q     <= 1'b0;
      u_addr_q    <= 16'd0;
      u_pos_q     <= 8'd0;
      v_pos_q     <= 8'd0;
      fb1_rd_q    <= 1'b0;
      fb1_addr_q  <= 16'd0;
      fb2_rd_q    <= 1'b0;
      fb2_addr_q  <= 16'd0;
      out_valid_q <= 1'b0;
      out_y_q     <= 8'd0;
      out_u_q     <= 8'd0;
      out_v_q     <= 8'd0;
      out_row_q   <= 10'd0;
      out_col_q   <= 10'd0;
      pos_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_pos_q     <= y_pos_d;
      u_buf_q     <= u_buf_d;
      u_addr_q    <= u_addr_d;
      u_pos_q     <= u_pos_d;
      v_pos_q     <= v_pos_d;
      fb1_rd_q    <= fb1_rd_d;
      fb1_addr_q  <= fb1_addr_d;
      fb2_rd_q    <= fb2_rd_d;
      fb2_addr_q  <= fb2_addr_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_u_q     <= out_u_d;
      out_v_q     <= out_v_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      pos_err_q   <= pos_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign fb1_rd    = fb1_rd_q;
  assign fb1_addr  = fb1_addr_q;
  assign fb2_rd    = fb2_rd_q;
  assign fb2_addr  = fb2_addr_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_u     = out_u_q;
  assign out_v     = out_v_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign pos_err   = pos_err_q;

endmodule

// File: tb/tb_yuv_pixel_fetch.sv
// -----------------------------------------------------------------------------
// tb_yuv_pixel_fetch
//
// Self-checking bench for yuv_pixel_fetch.
//
// Both frame buffers are modelled as sparse memories filled with random words.
// Each memory answers the cycle after a strobe; other cycles return random junk.
//
// A monitor samples on the falling edge and keeps one expected transaction.
// That transaction is computed when a request is accepted:
//   - the samples, using shift-and-mask on the memory words and the offset limits;
//   - the sticky error;
//   - the list of (cycle-after-accept, address) strobes each buffer must see.
//
// The monitor checks the following:
//   - req_ready matches whether a transaction is outstanding;
//   - strobes appear only inside a transaction;
//   - out_valid rises exactly four cycles after acceptance;
//   - the outputs match the expectation in every out_valid cycle;
//   - the observed strobes match the expected list at the handshake.
// -----------------------------------------------------------------------------
module tb_yuv_pixel_fetch;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [9:0]   row, col;
  logic [15:0]  y_addr;
  logic [5:0]   y_pos;
  logic         u_buf;
  logic [15:0]  u_addr;
  logic [7:0]   u_pos;
  logic [12:0]  v_addr;
  logic [7:0]   v_pos;
  logic         fb1_rd;
  logic [15:0]  fb1_addr;
  logic [39:0]  fb1_data;
  logic         fb2_rd;
  logic [15:0]  fb2_addr;
  logic [143:0] fb2_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_y, out_u, out_v;
  logic [9:0]   out_row, out_col;
  logic         pos_err;

  always #5 clk = ~clk;

  yuv_pixel_fetch dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .row(row), .col(col),
    .y_addr(y_addr), .y_pos(y_pos),
    .u_buf(u_buf), .u_addr(u_addr), .u_pos(u_pos),
    .v_addr(v_addr), .v_pos(v_pos),
    .fb1_rd(fb1_rd), .fb1_addr(fb1_addr), .fb1_data(fb1_data),
    .fb2_rd(fb2_rd), .fb2_addr(fb2_addr), .fb2_data(fb2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_u(out_u), .out_v(out_v),
    .out_row(out_row), .out_col(out_col),
    .pos_err(pos_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- frame buffer models ----------------
  logic [39:0]  fb1_mem [int];
  logic [143:0] fb2_mem [int];

  function automatic logic [39:0] rd1(input logic [15:0] a);
    if (!fb1_mem.exists(int'(a))) fb1_mem[int'(a)] = 40'({$urandom, $urandom});
    return fb1_mem[int'(a)];
  endfunction

  function automatic logic [143:0] rd2(input logic [15:0] a);
    if (!fb2_mem.exists(int'(a)))
      fb2_mem[int'(a)] = 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
    return fb2_mem[int'(a)];
  endfunction

  always @(posedge clk) begin
    fb1_data <= fb1_rd ? rd1(fb1_addr) : 40'({$urandom, $urandom});
    fb2_data <= fb2_rd ? rd2(fb2_addr)
                       : 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
  end

  // Byte at bit offset pos of a word, or 0 when pos is above limit.
  function automatic logic [7:0] sample(input logic [143:0] w, input int pos, input int limit);
    logic [143:0] t;
    if (pos > limit) return 8'h00;
    t = w >> pos;
    return t[7:0];
  endfunction

  // ---------------- monitor / reference model ----------------
  int          cyc = 0;
  bit          busy = 1'b0;
  bit          err_model = 1'b0;
  int          acc_cyc;
  int          hs_cnt = 0;
  int          acc_log[$];
  logic [7:0]  ey, eu, ev;
  logic [9:0]  erow, ecol;
  bit          eerr;
  logic [19:0] exp1[$], exp2[$], obs1[$], obs2[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      busy = 1'b0;
      err_model = 1'b0;
      exp1.delete(); exp2.delete(); obs1.delete(); obs2.delete();
    end else begin
      check_eq("req_ready", req_ready, !busy);
      if (busy) begin
        if (fb1_rd) obs1.push_back({4'(cyc - acc_cyc), fb1_addr});
        if (fb2_rd) obs2.push_back({4'(cyc - acc_cyc), fb2_addr});
        if (cyc - acc_cyc < 4) check_eq("early_valid", out_valid, 1'b0);
        else if (cyc - acc_cyc == 4) check_eq("latency_valid", out_valid, 1'b1);
        if (cyc - acc_cyc > 300) begin
          check_eq("txn_timeout", 1'b0, 1'b1);
          busy = 1'b0;
        end
        if (out_valid) begin
          check_eq("out_y", out_y, ey);
          check_eq("out_u", out_u, eu);
          check_eq("out_v", out_v, ev);
          check_eq("out_row", out_row, erow);
          check_eq("out_col", out_col, ecol);
          check_eq("pos_err", pos_err, eerr);
          if (out_ready) begin
            check_eq("fb1_nstrobe", obs1.size(), exp1.size());
            check_eq("fb2_nstrobe", obs2.size(), exp2.size());
            for (int i = 0; i < obs1.size() && i < exp1.size(); i++)
              check_eq("fb1_strobe", obs1[i], exp1[i]);
            for (int i = 0; i < obs2.size() && i < exp2.size(); i++)
              check_eq("fb2_strobe", obs2[i], exp2[i]);
            hs_cnt++;
            busy = 1'b0;
          end
        end
      end else begin
        check_eq("stray_fb1_rd", fb1_rd, 1'b0);
        check_eq("stray_fb2_rd", fb2_rd, 1'b0);
        check_eq("stray_valid", out_valid, 1'b0);
        if (req_valid && req_ready) begin
          ey   = sample(144'(rd1(y_addr)), int'(y_pos), 32);
          ev   = sample(rd2({3'b000, v_addr}), int'(v_pos), 136);
          eu   = u_buf ? sample(rd2(u_addr), int'(u_pos), 136)
                       : sample(144'(rd1(u_addr)), int'(u_pos), 32);
          erow = row;
          ecol = col;
          if (y_pos > 32 || v_pos > 136 || int'(u_pos) > (u_buf ? 136 : 32)) err_model = 1'b1;
          eerr = err_model;
          exp1.delete(); exp2.delete(); obs1.delete(); obs2.delete();
          exp1.push_back({4'd1, y_addr});
          exp2.push_back({4'd1, 3'b000, v_addr});
          if (u_buf) exp2.push_back({4'd2, u_addr});
          else       exp1.push_back({4'd2, u_addr});
          acc_cyc = cyc;
          acc_log.push_back(cyc);
          busy = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [9:0] r, input logic [9:0] c,
                      input logic [15:0] ya, input logic [5:0] yp,
                      input logic ub, input logic [15:0] ua, input logic [7:0] up,
                      input logic [12:0] va, input logic [7:0] vp);
    bit ok;
    row = r; col = c; y_addr = ya; y_pos = yp; u_buf = ub;
    u_addr = ua; u_pos = up; v_addr = va; v_pos = vp;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (req_ready && !reset) ok = 1'b1;
    end
    if (!ok) check_eq("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic       ub;
    logic [5:0] yp;
    logic [7:0] up, vp;
    ub = 1'($urandom);
    yp = ($urandom % 8 == 0) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(0, 32));
    vp = ($urandom % 8 == 0) ? 8'($urandom_range(137, 255)) : 8'($urandom_range(0, 136));
    if (ub) up = ($urandom % 8 == 0) ? 8'($urandom_range(137, 255)) : 8'($urandom_range(0, 136));
    else    up = ($urandom % 8 == 0) ? 8'($urandom_range(33, 255)) : 8'($urandom_range(0, 32));
    send(10'($urandom), 10'($urandom), 16'($urandom), yp, ub, 16'($urandom), up,
         13'($urandom), vp);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk);
      #1;
      if (!busy) ok = 1'b1;
    end
    if (!ok) check_eq("idle_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    bit rand_done;
    int n0, h0;
    reset = 1'b1; req_valid = 1'b0; out_ready = 1'b1;
    row = 10'd0; col = 10'd0; y_addr = 16'd0; y_pos = 6'd0; u_buf = 1'b0;
    u_addr = 16'd0; u_pos = 8'd0; v_addr = 13'd0; v_pos = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state, first cycle after reset.
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_fb1_rd", fb1_rd, 1'b0);
    check_eq("rst_fb2_rd", fb2_rd, 1'b0);
    check_eq("rst_fb1_addr", fb1_addr, 16'd0);
    check_eq("rst_fb2_addr", fb2_addr, 16'd0);
    check_eq("rst_outs", {out_y, out_u, out_v, out_row, out_col}, 44'd0);
    check_eq("rst_pos_err", pos_err, 1'b0);
    @(posedge clk); #1;

    // Y/V fetch: FB1[3] byte at bit 16 = 0x33, FB2[7] top byte = 0xAB.
    fb1_mem[3] = 40'h11_22_33_44_55;
    fb2_mem[7] = {8'hAB, 136'({$urandom, $urandom, $urandom, $urandom, $urandom})};
    send(10'd1, 10'd2, 16'd3, 6'd16, 1'b0, 16'h0040, 8'd8, 13'd7, 8'd136);
    wait_idle();
    check_eq("yv_y_const", out_y, 8'h33);
    check_eq("yv_v_const", out_v, 8'hAB);

    // U in FB2 at offset 0.
    send(10'd3, 10'd4, 16'h1234, 6'd0, 1'b1, 16'h0100, 8'd0, 13'h0abc, 8'd5);
    wait_idle();
    check_eq("ufb2_u_const", out_u, fb2_mem[16'h0100][7:0]);

    // Backpressure for well over 10 cycles, then a single handshake.
    out_ready = 1'b0;
    h0 = hs_cnt;
    send(10'd5, 10'd6, 16'h0777, 6'd3, 1'b0, 16'h0778, 8'd27, 13'h1fff, 8'd77);
    repeat (14) @(posedge clk);
    #1;
    check_eq("bp_no_hs", hs_cnt - h0, 0);
    check_eq("bp_holding", out_valid, 1'b1);
    out_ready = 1'b1;
    wait_idle();
    check_eq("bp_one_hs", hs_cnt - h0, 1);

    // Back-to-back with req_valid held high: one accept every 5 cycles.
    n0 = acc_log.size();
    for (int i = 0; i < 4; i++)
      send(10'(100 + i), 10'(200 + i), 16'($urandom), 6'($urandom_range(0, 32)), 1'($urandom),
           16'($urandom), 8'($urandom_range(0, 32)), 13'($urandom), 8'($urandom_range(0, 136)));
    wait_idle();
    for (int i = n0 + 1; i < acc_log.size(); i++)
      check_eq("b2b_spacing", acc_log[i] - acc_log[i - 1], 5);

    // Randomized traffic with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom % 3 == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
          send_rand();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom % 4) != 0;
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();

    // Offset error on Y: byte is 0 and the flag sticks across later requests.
    send(10'd7, 10'd8, 16'h0010, 6'd40, 1'b0, 16'h0011, 8'd0, 13'd1, 8'd0);
    wait_idle();
    check_eq("err_y_zero", out_y, 8'h00);
    check_eq("err_flag", pos_err, 1'b1);
    send(10'd9, 10'd10, 16'h0012, 6'd8, 1'b0, 16'h0013, 8'd8, 13'd2, 8'd8);
    wait_idle();
    check_eq("err_sticky", pos_err, 1'b1);

    // Reset in RD_B: fetch abandoned, IDLE next cycle, flag cleared.
    send(10'd11, 10'd12, 16'h0020, 6'd0, 1'b1, 16'h0021, 8'd0, 13'd3, 8'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("mr_req_ready", req_ready, 1'b1);
    check_eq("mr_pos_err", pos_err, 1'b0);
    check_eq("mr_out_valid", out_valid, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    send(10'd13, 10'd14, 16'h0030, 6'd24, 1'b0, 16'h0031, 8'd32, 13'd4, 8'd128);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
